// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file slice.
package regfile_pkg;

    // Default architectural sizing.
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    // Ports per pipeline stage: decode reads, write-back writes.
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_PORTS = 2;

    // LSB position of lane `port` inside a packed bus of `width`-bit lanes.
    function automatic int slice_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue marks a destination pending, write-back clears it.
// Produces per-read-port stall flags and a registered popcount of busy bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en   [NUM_WR_PORTS],
    input  logic [ADDR_W-1:0]        wr_addr [NUM_WR_PORTS],
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_n;
    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] set;
    logic [ADDR_W:0]  cnt_n;

    // Decode write-back clears and issue sets; set overrides clear so a new producer supersedes.
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        clr    = '0;
        set    = '0;
        busy_n = '0;
        cnt_n  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && wr_addr[p] == ADDR_W'(i))
                    clr[i] = 1'b1;
            end
            set[i]    = iss_en && iss_addr == ADDR_W'(i) && !(ZERO_REG && i == 0);
            busy_n[i] = (busy[i] & ~clr[i]) | set[i];
            cnt_n     = cnt_n + (ADDR_W+1)'(busy_n[i]);
        end
    end

    // Busy vector and its population count advance together.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_n;
            busy_cnt <= cnt_n;
        end
    end

    // Operand is pending unless it is being written back this very cycle (matches the bypass).
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy[k] = busy[rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]]
                       & ~clr[rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports with same-cycle
// write bypass, two write-back ports (port 1 wins on collision), and a
// busy-bit scoreboard for decode hazard stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    // Write ports gathered in priority order: a higher index overrides a lower one.
    logic              wr_en   [NUM_WR_PORTS];
    logic [ADDR_W-1:0] wr_addr [NUM_WR_PORTS];
    logic [DATA_W-1:0] wr_data [NUM_WR_PORTS];

    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_en[0]   = wr0_en;
    assign wr_addr[0] = wr0_addr;
    assign wr_data[0] = wr0_data;
    assign wr_en[1]   = wr1_en;
    assign wr_addr[1] = wr1_addr;
    assign wr_data[1] = wr1_data;

    // Storage update; later ports are assigned last so wr1 wins on a shared index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset explicitly because architectural registers must read 0 after reset; this keeps it in flops, not RAM.
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && !(ZERO_REG && wr_addr[p] == '0))
                    mem[wr_addr[p]] <= wr_data[p];
            end
        end
    end

    // Read muxes with write bypass; register 0 is hard-wired to zero when enabled.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data[slice_lsb(k, DATA_W) +: DATA_W] = mem[rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W]];
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
                if (wr_en[p] && wr_addr[p] == rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W])
                    rd_data[slice_lsb(k, DATA_W) +: DATA_W] = wr_data[p];
            end
            if (ZERO_REG && rd_addr[slice_lsb(k, ADDR_W) +: ADDR_W] == '0)
                rd_data[slice_lsb(k, DATA_W) +: DATA_W] = '0;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr0_en, wr1_en, iss_en;
    logic [ADDR_W-1:0]        wr0_addr, wr1_addr, iss_addr;
    logic [DATA_W-1:0]        wr0_data, wr1_data;
    logic [ADDR_W:0]          busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then move 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0;
        wr1_en = 1'b0;
        iss_en = 1'b0;
    endtask

    function automatic logic [31:0] rdat(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: ADDR_W]      = ADDR_W'(a0);
        rd_addr[ADDR_W +: ADDR_W] = ADDR_W'(a1);
    endtask

    initial begin
        rst      = 1'b1;
        idle();
        wr0_addr = '0; wr0_data = '0;
        wr1_addr = '0; wr1_data = '0;
        iss_addr = '0;
        set_rd(5, 6);
        #1;
        check("reset_rd0", rdat(0), 32'h0);
        check("reset_cnt", 32'(busy_cnt), 32'h0);
        step();
        rst = 1'b0;

        // Write R5=0xDEAD and issue R6, then assert reset without a clock edge.
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h0000_DEAD;
        iss_en = 1'b1; iss_addr = 5'd6;
        step();
        idle();
        #1;
        check("pre_rst_r5", rdat(0), 32'h0000_DEAD);
        check("pre_rst_busy6", 32'(rd_busy[1]), 32'h1);
        check("pre_rst_cnt", 32'(busy_cnt), 32'h1);
        rst = 1'b1;
        #1;
        check("async_rst_r5", rdat(0), 32'h0);
        check("async_rst_busy", 32'(rd_busy), 32'h0);
        check("async_rst_cnt", 32'(busy_cnt), 32'h0);
        step();
        rst = 1'b0;
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h0000_1234;
        step();
        idle();
        #1;
        check("post_rst_r5", rdat(0), 32'h0000_1234);

        // Bypass on read port 0.
        set_rd(3, 5);
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hAAAA_0001;
        #1;
        check("bypass_r3", rdat(0), 32'hAAAA_0001);
        step();
        idle();
        #1;
        check("stored_r3", rdat(0), 32'hAAAA_0001);
        check("nonbusy_write_cnt", 32'(busy_cnt), 32'h0);

        // Write collision: wr1 wins.
        set_rd(3, 7);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        #1;
        check("collide_bypass", rdat(1), 32'h22);
        step();
        idle();
        #1;
        check("collide_stored", rdat(1), 32'h22);

        // Zero register ignores writes and issues.
        set_rd(0, 7);
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check("r0_bypass", rdat(0), 32'h0);
        step();
        idle();
        #1;
        check("r0_stored", rdat(0), 32'h0);
        check("r0_busy", 32'(rd_busy[0]), 32'h0);
        check("r0_cnt", 32'(busy_cnt), 32'h0);

        // Scoreboard: issue takes effect next cycle, write-back clears same cycle.
        set_rd(9, 0);
        iss_en = 1'b1; iss_addr = 5'd9;
        #1;
        check("iss_same_cycle", 32'(rd_busy[0]), 32'h0);
        step();
        idle();
        #1;
        check("iss_busy9", 32'(rd_busy[0]), 32'h1);
        check("iss_cnt1", 32'(busy_cnt), 32'h1);
        wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h55;
        #1;
        check("wb_busy9", 32'(rd_busy[0]), 32'h0);
        check("wb_data9", rdat(0), 32'h55);
        check("wb_cnt_still1", 32'(busy_cnt), 32'h1);
        step();
        idle();
        #1;
        check("wb_cnt0", 32'(busy_cnt), 32'h0);

        // Set/clear race on R4: set wins.
        set_rd(0, 4);
        iss_en = 1'b1; iss_addr = 5'd4;
        step();
        idle();
        #1;
        check("race_pre_cnt", 32'(busy_cnt), 32'h1);
        wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'h44;
        iss_en = 1'b1; iss_addr = 5'd4;
        #1;
        check("race_same_cycle_busy", 32'(rd_busy[1]), 32'h0);
        step();
        idle();
        #1;
        check("race_busy4", 32'(rd_busy[1]), 32'h1);
        check("race_cnt", 32'(busy_cnt), 32'h1);
        check("race_data4", rdat(1), 32'h44);

        // Fill every index (R0 must be ignored, R4 already busy).
        for (int i = 0; i < 32; i++) begin
            iss_en = 1'b1; iss_addr = ADDR_W'(i);
            step();
        end
        idle();
        #1;
        check("fill_cnt31", 32'(busy_cnt), 32'd31);

        // Two write-backs in one cycle clear two busy bits.
        set_rd(31, 1);
        wr0_en = 1'b1; wr0_addr = 5'd1;  wr0_data = 32'h1;
        wr1_en = 1'b1; wr1_addr = 5'd31; wr1_data = 32'h31;
        #1;
        check("dual_wb_busy", 32'(rd_busy), 32'h0);
        step();
        idle();
        #1;
        check("dual_wb_cnt29", 32'(busy_cnt), 32'd29);
        check("dual_wb_still_busy_r2", 32'(dut.u_scoreboard.busy[2]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
